control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 22 ++
 rtl/control_unit.sv | 197 +++++++++++++++++++
 tb/tb_control_unit.sv | 531 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// control_unit_if: instruction fetch bus.
// master drives pc/instr_req, slave returns instr/instr_valid.
interface control_unit_if;
  logic        instr_req;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic        instr_valid;

  modport master (
    output instr_req,
    output pc,
    input  instr,
    input  instr_valid
  );

  modport slave (
    input  instr_req,
    input  pc,
    output instr,
    output instr_valid
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer.
// Define CTRL_ILLEGAL_TRAP_EN to halt on illegal opcodes.
module control_unit (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           start,
  control_unit_if.master fetch,
  output logic [3:0]     read_reg1,
  output logic [3:0]     read_reg2,
  output logic [3:0]     write_reg,
  output logic [3:0]     alu_imm_val,
  output logic [7:0]     address,
  output logic           we,
  output logic           mem_store,
  output logic           mem_load,
  output logic           alu_imm,
  output logic           alu_slc,
  output logic           halted,
  output logic           illegal
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic [15:0] ir_nxt;
  logic [7:0]  pc_q;
  logic [7:0]  pc_nxt;
  logic        ill_q;
  logic        ill_nxt;

  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] rs1;
  logic [3:0] rs2;
  logic [7:0] addr8;
  logic       busy;

  logic is_nop;
  logic is_alur;
  logic is_alui;
  logic is_ld;
  logic is_st;
  logic is_jmp;
  logic is_halt;
  logic is_bad;

  assign op    = ir[15:12];
  assign rd    = ir[11:8];
  assign rs1   = ir[7:4];
  assign rs2   = ir[3:0];
  assign addr8 = ir[7:0];

  assign busy = state inside {DECODE, EXEC, MEM, WB};

  assign fetch.pc = pc_q;
  assign halted   = (state == HALT);
  assign illegal  = ill_q;

  // Split the latched opcode into one-hot classes.
  always_comb begin
    is_nop  = (op == 4'h0);
    is_alur = (op == 4'h1) || (op == 4'h2);
    is_alui = (op == 4'h3) || (op == 4'h4);
    is_ld   = (op == 4'h5);
    is_st   = (op == 4'h6);
    is_jmp  = (op == 4'h7);
    is_halt = (op == 4'hF);
    is_bad  = op[3] && (op != 4'hF);
  end

  // Operand fields stay on the register-file ports from DECODE to WB.
  always_comb begin
    read_reg1   = 4'd0;
    read_reg2   = 4'd0;
    alu_imm_val = 4'd0;
    if (busy) begin
      read_reg1   = (is_ld || is_st) ? rd : rs1;
      read_reg2   = rs2;
      alu_imm_val = rs2;
    end
  end

  // Next state, pc/ir updates and one-cycle datapath strobes.
  always_comb begin
    state_nxt       = state;
    ir_nxt          = ir;
    pc_nxt          = pc_q;
    ill_nxt         = ill_q;
    fetch.instr_req = 1'b0;
    write_reg       = 4'd0;
    address         = 8'd0;
    we              = 1'b0;
    mem_store       = 1'b0;
    mem_load        = 1'b0;
    alu_imm         = 1'b0;
    alu_slc         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        fetch.instr_req = 1'b1;
        if (fetch.instr_valid) begin
          ir_nxt    = fetch.instr;
          pc_nxt    = pc_q + 8'd1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = FETCH;
        unique case (1'b1)
          is_nop: begin
          end
          is_alur: begin
            we        = 1'b1;
            write_reg = rd;
            alu_slc   = ~op[0];
          end
          is_alui: begin
            we        = 1'b1;
            write_reg = rd;
            alu_imm   = 1'b1;
            alu_slc   = op[0];
          end
          is_ld: begin
            state_nxt = MEM;
          end
          is_st: begin
            mem_store = 1'b1;
            address   = addr8;
          end
          is_jmp: begin
            pc_nxt = addr8;
          end
          is_halt: begin
            state_nxt = HALT;
          end
          is_bad: begin
            ill_nxt = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_nxt = HALT;
`else
            state_nxt = FETCH;
`endif
          end
          default: begin
          end
        endcase
      end
      MEM: begin
        mem_load  = 1'b1;
        address   = addr8;
        state_nxt = WB;
      end
      WB: begin
        we        = 1'b1;
        write_reg = rd;
        state_nxt = FETCH;
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and architectural registers; clr_n clears them at once.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      ir    <= 16'h0000;
      pc_q  <= 8'h00;
      ill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ir    <= ir_nxt;
      pc_q  <= pc_nxt;
      ill_q <= ill_nxt;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit.
// Expected strobe events are queued per instruction.
module tb_control_unit;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] wreg;
    logic [7:0] addr;
    logic       imm;
    logic       slc;
    logic [3:0] r1;
    logic [3:0] r2;
    logic [3:0] iv;
    logic [7:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       start;
  logic [3:0] read_reg1;
  logic [3:0] read_reg2;
  logic [3:0] write_reg;
  logic [3:0] alu_imm_val;
  logic [7:0] address;
  logic       we;
  logic       mem_store;
  logic       mem_load;
  logic       alu_imm;
  logic       alu_slc;
  logic       halted;
  logic       illegal;

  int checks = 0;
  int failures = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];

  logic [3:0] dec_r1;
  logic [3:0] dec_r2;
  logic [3:0] dec_iv;

  control_unit_if fetch_bus();

  control_unit dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .start       (start),
    .fetch       (fetch_bus),
    .read_reg1   (read_reg1),
    .read_reg2   (read_reg2),
    .write_reg   (write_reg),
    .alu_imm_val (alu_imm_val),
    .address     (address),
    .we          (we),
    .mem_store   (mem_store),
    .mem_load    (mem_load),
    .alu_imm     (alu_imm),
    .alu_slc     (alu_slc),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  function automatic ev_t mk(
    input logic [1:0] k, input logic [3:0] wr,
    input logic [7:0] a, input logic im, input logic sl,
    input logic [3:0] r1, input logic [3:0] r2,
    input logic [3:0] iv, input logic [7:0] c);
    ev_t e;
    e.kind = k; e.wreg = wr; e.addr = a;
    e.imm = im; e.slc = sl;
    e.r1 = r1; e.r2 = r2; e.iv = iv; e.cyc = c;
    return e;
  endfunction

  function automatic ev_t sample(input int c);
    ev_t e;
    int n;
    n = int'(we === 1'b1) + int'(mem_store === 1'b1)
      + int'(mem_load === 1'b1);
    if (n != 1) e.kind = 2'd0;
    else if (we === 1'b1) e.kind = 2'd1;
    else if (mem_store === 1'b1) e.kind = 2'd2;
    else e.kind = 2'd3;
    e.wreg = write_reg; e.addr = address;
    e.imm = alu_imm; e.slc = alu_slc;
    e.r1 = read_reg1; e.r2 = read_reg2;
    e.iv = alu_imm_val; e.cyc = 8'(c);
    return e;
  endfunction

  function automatic logic [39:0] all_out();
    return {fetch_bus.instr_req, fetch_bus.pc,
            read_reg1, read_reg2, write_reg,
            alu_imm_val, address, we, mem_store,
            mem_load, alu_imm, alu_slc, halted, illegal};
  endfunction

  task automatic do_reset();
    clr_n = 1'b0;
    start = 1'b0;
    fetch_bus.instr_valid = 1'b0;
    fetch_bus.instr = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for a fetch, hands over w, records strobes until the next fetch.
  task automatic run_instr(input logic [15:0] w,
                           output int lat, output bit to);
    int n;
    to = 1'b0;
    n = 0;
    lat = 0;
    while (fetch_bus.instr_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (fetch_bus.instr_req !== 1'b1) begin
      to = 1'b1;
      return;
    end
    fetch_bus.instr = w;
    fetch_bus.instr_valid = 1'b1;
    @(negedge clk);
    fetch_bus.instr_valid = 1'b0;
    fetch_bus.instr = 16'hE5E5;
    dec_r1 = read_reg1;
    dec_r2 = read_reg2;
    dec_iv = alu_imm_val;
    lat = 1;
    while (fetch_bus.instr_req !== 1'b1 && halted !== 1'b1
           && lat < 20) begin
      lat++;
      if (we === 1'b1 || mem_store === 1'b1 || mem_load === 1'b1)
        obs_q.push_back(sample(lat));
      @(negedge clk);
    end
    if (lat >= 20) to = 1'b1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    start = 1'b0;
    fetch_bus.instr_valid = 1'b0;
    fetch_bus.instr = 16'h0000;
    #2;
    checks++;
    if (all_out() !== 40'd0) begin
      failures++;
      $display("FAIL reset_outs got=%h required=0", all_out());
    end
    @(negedge clk);
    clr_n = 1'b1;
    fetch_bus.instr_valid = 1'b1;
    fetch_bus.instr = 16'h1123;
    repeat (3) @(negedge clk);
    fetch_bus.instr_valid = 1'b0;
    checks++;
    if (all_out() !== 40'd0) begin
      failures++;
      $display("FAIL idle_hold got=%h required=0", all_out());
    end
  endtask

  task automatic test_alu_r();
    int lat;
    bit to;
    ev_t e;
    ev_t o;
    do_reset();
    do_start();
    checks++;
    if (fetch_bus.instr_req !== 1'b1 || fetch_bus.pc !== 8'h00) begin
      failures++;
      $display("FAIL start_req got req=%b pc=%h required req=1 pc=00",
               fetch_bus.instr_req, fetch_bus.pc);
    end
    exp_q.push_back(mk(2'd1, 4'd1, 8'h00, 1'b0, 1'b0,
                       4'd2, 4'd3, 4'd3, 8'd3));
    run_instr(16'h1123, lat, to);
    checks++;
    if ({to, dec_r1, dec_r2} !== {1'b0, 4'd2, 4'd3}) begin
      failures++;
      $display("FAIL alur_decode got to=%b r1=%h r2=%h required 0/2/3",
               to, dec_r1, dec_r2);
    end
    checks++;
    if (lat !== 3 || fetch_bus.pc !== 8'h01) begin
      failures++;
      $display("FAIL alur_lat got lat=%0d pc=%h required 3/01",
               lat, fetch_bus.pc);
    end
    exp_q.push_back(mk(2'd1, 4'd4, 8'h00, 1'b0, 1'b1,
                       4'd5, 4'd6, 4'd6, 8'd3));
    run_instr(16'h2456, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 3 || fetch_bus.pc !== 8'h02) begin
      failures++;
      $display("FAIL alur1_lat got to=%b lat=%0d pc=%h required 0/3/02",
               to, lat, fetch_bus.pc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL alur_sb got=none required=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL alur_sb got=%h required=%h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL alur_extra got=%0d required=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_alu_i();
    int lat;
    bit to;
    ev_t e;
    ev_t o;
    exp_q.push_back(mk(2'd1, 4'd5, 8'h00, 1'b1, 1'b0,
                       4'hA, 4'd7, 4'd7, 8'd3));
    run_instr(16'h45A7, lat, to);
    checks++;
    if ({to, dec_r1, dec_iv} !== {1'b0, 4'hA, 4'd7} || lat !== 3) begin
      failures++;
      $display("FAIL alui1 got to=%b r1=%h iv=%h lat=%0d required 0/a/7/3",
               to, dec_r1, dec_iv, lat);
    end
    exp_q.push_back(mk(2'd1, 4'd7, 8'h00, 1'b1, 1'b1,
                       4'd8, 4'd9, 4'd9, 8'd3));
    run_instr(16'h3789, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 3) begin
      failures++;
      $display("FAIL alui0 got to=%b lat=%0d required 0/3", to, lat);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL alui_sb got=none required=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL alui_sb got=%h required=%h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL alui_extra got=%0d required=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_load();
    int lat;
    bit to;
    ev_t e;
    ev_t o;
    exp_q.push_back(mk(2'd3, 4'd0, 8'h42, 1'b0, 1'b0,
                       4'd3, 4'd2, 4'd2, 8'd4));
    exp_q.push_back(mk(2'd1, 4'd3, 8'h00, 1'b0, 1'b0,
                       4'd3, 4'd2, 4'd2, 8'd5));
    run_instr(16'h5342, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 5 || dec_r1 !== 4'd3) begin
      failures++;
      $display("FAIL ld_lat got to=%b lat=%0d r1=%h required 0/5/3",
               to, lat, dec_r1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL ld_sb got=none required=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL ld_sb got=%h required=%h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL ld_extra got=%0d required=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_wrap_store_jmp();
    int lat;
    bit to;
    ev_t e;
    ev_t o;
    run_instr(16'h70FF, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 3 || fetch_bus.pc !== 8'hFF) begin
      failures++;
      $display("FAIL jmp_ff got to=%b lat=%0d pc=%h required 0/3/ff",
               to, lat, fetch_bus.pc);
    end
    exp_q.push_back(mk(2'd2, 4'd0, 8'h80, 1'b0, 1'b0,
                       4'd2, 4'd0, 4'd0, 8'd3));
    run_instr(16'h6280, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 3 || fetch_bus.pc !== 8'h00) begin
      failures++;
      $display("FAIL st_wrap got to=%b lat=%0d pc=%h required 0/3/00",
               to, lat, fetch_bus.pc);
    end
    run_instr(16'h7010, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 3 || fetch_bus.pc !== 8'h10) begin
      failures++;
      $display("FAIL jmp_10 got to=%b lat=%0d pc=%h required 0/3/10",
               to, lat, fetch_bus.pc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL st_sb got=none required=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL st_sb got=%h required=%h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL st_extra got=%0d required=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_fetch_stall();
    int lat;
    bit to;
    int bad;
    bad = 0;
    start = 1'b1;
    fetch_bus.instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (fetch_bus.instr_req !== 1'b1 || fetch_bus.pc !== 8'h10
          || {we, mem_store, mem_load} !== 3'b000)
        bad++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall got bad_cycles=%0d required=0", bad);
    end
    run_instr(16'h0000, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 3 || fetch_bus.pc !== 8'h11
        || obs_q.size() != 0) begin
      failures++;
      $display("FAIL nop got to=%b lat=%0d pc=%h ev=%0d required 0/3/11/0",
               to, lat, fetch_bus.pc, obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    fetch_bus.instr = 16'h5111;
    fetch_bus.instr_valid = 1'b1;
    @(negedge clk);
    fetch_bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_load !== 1'b1) begin
      failures++;
      $display("FAIL mid_mem got mem_load=%b required=1", mem_load);
    end
    clr_n = 1'b0;
    #1;
    checks++;
    if (all_out() !== 40'd0) begin
      failures++;
      $display("FAIL mid_async got=%h required=0", all_out());
    end
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({we, mem_store, mem_load, fetch_bus.instr_req} !== 4'b0000
        || fetch_bus.pc !== 8'h00) begin
      failures++;
      $display("FAIL mid_after got strobes=%b req=%b pc=%h required 000/0/00",
               {we, mem_store, mem_load}, fetch_bus.instr_req,
               fetch_bus.pc);
    end
  endtask

  task automatic test_illegal();
    int lat;
    bit to;
    int bad;
    do_reset();
    do_start();
    run_instr(16'h9000, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 3 || illegal !== 1'b1
        || obs_q.size() != 0) begin
      failures++;
      $display("FAIL ill_exec got to=%b lat=%0d ill=%b ev=%0d required 0/3/1/0",
               to, lat, illegal, obs_q.size());
      obs_q.delete();
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (fetch_bus.instr_req !== 1'b0 || halted !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ill_trap got bad_cycles=%0d required=0", bad);
    end
`else
    checks++;
    if (halted !== 1'b0 || fetch_bus.instr_req !== 1'b1
        || fetch_bus.pc !== 8'h01) begin
      failures++;
      $display("FAIL ill_cont got halt=%b req=%b pc=%h required 0/1/01",
               halted, fetch_bus.instr_req, fetch_bus.pc);
    end
    run_instr(16'h0000, lat, to);
    bad = int'(to);
    checks++;
    if (bad != 0 || illegal !== 1'b1 || fetch_bus.pc !== 8'h02) begin
      failures++;
      $display("FAIL ill_sticky got to=%0d ill=%b pc=%h required 0/1/02",
               bad, illegal, fetch_bus.pc);
    end
`endif
  endtask

  task automatic test_halt();
    int lat;
    bit to;
    int bad;
    do_reset();
    do_start();
    run_instr(16'hF000, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 3 || halted !== 1'b1
        || illegal !== 1'b0) begin
      failures++;
      $display("FAIL halt got to=%b lat=%0d halt=%b ill=%b required 0/3/1/0",
               to, lat, halted, illegal);
    end
    bad = 0;
    start = 1'b1;
    fetch_bus.instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (fetch_bus.instr_req !== 1'b0 || halted !== 1'b1
          || fetch_bus.pc !== 8'h01
          || {we, mem_store, mem_load} !== 3'b000)
        bad++;
      @(negedge clk);
    end
    start = 1'b0;
    fetch_bus.instr_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL halt_hold got bad_cycles=%0d required=0", bad);
    end
    clr_n = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || fetch_bus.pc !== 8'h00) begin
      failures++;
      $display("FAIL halt_clr got halt=%b pc=%h required 0/00",
               halted, fetch_bus.pc);
    end
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_r();
    test_alu_i();
    test_load();
    test_wrap_store_jmp();
    test_fetch_stall();
    test_reset_mid();
    test_illegal();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
